// File: rtl/read_stream_cmd_gen.sv
// Splits a (base_addr, num_elements) read job into power-of-2 sized read
// commands, bounded by a credit count of commands still awaiting a response.
module read_stream_cmd_gen #(
  parameter int ELEM_BYTES      = 4,
  parameter int MAX_CMD_BYTES   = 128,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TAG_WIDTH       = 8,
  parameter int ROUND_UP        = 1
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [63:0]          base_addr_i,
  input  logic [31:0]          num_elements_i,
  output logic                 cmd_valid_o,
  output logic [63:0]          cmd_addr_o,
  output logic [11:0]          cmd_size_o,
  output logic [TAG_WIDTH-1:0] cmd_tag_o,
  input  logic                 cmd_ready_i,
  input  logic                 rsp_valid_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int ELEM_SHIFT = $clog2(ELEM_BYTES);
  localparam int MAX_LOG    = $clog2(MAX_CMD_BYTES);

  typedef enum logic [2:0] {
    S_RESET,
    S_IDLE,
    S_SET,
    S_START,
    S_FINAL
  } state_t;

  state_t               state_q;
  logic [63:0]          addr_q;
  logic [39:0]          rem_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [7:0]           out_q;
  logic                 done_q;

  logic [11:0] size_d;
  logic [11:0] align_d;
  logic [11:0] limit_d;
  logic [39:0] rem_d;
  logic        hs;
  logic        rsp_take;

  // Command size is derived purely from the registered address / remainder.
  always_comb begin
    size_d  = 12'd0;
    align_d = 12'(MAX_CMD_BYTES);
    limit_d = 12'd0;
    if (ROUND_UP != 0) begin
      if (rem_q >= 40'(MAX_CMD_BYTES)) begin
        size_d = 12'(MAX_CMD_BYTES);
      end else if (rem_q != 40'd0) begin
        for (int i = MAX_LOG; i >= 0; i--) begin
          if ((40'd1 << i) >= rem_q) size_d = 12'd1 << i;
        end
      end
    end else begin
      for (int i = MAX_LOG - 1; i >= 0; i--) begin
        if (addr_q[i]) align_d = 12'd1 << i;
      end
      limit_d = (rem_q < 40'(align_d)) ? rem_q[11:0] : align_d;
      for (int i = 0; i <= MAX_LOG; i++) begin
        if ((12'd1 << i) <= limit_d) size_d = 12'd1 << i;
      end
    end
  end

  // Over-read sizing may exceed the remainder, so the remainder saturates.
  assign rem_d = (rem_q >= 40'(size_d)) ? rem_q - 40'(size_d) : 40'd0;

  assign cmd_valid_o = (state_q == S_START) && (rem_q != 40'd0) &&
                       (out_q < 8'(MAX_OUTSTANDING));
  assign hs          = cmd_valid_o && cmd_ready_i;
  assign rsp_take    = rsp_valid_i && (out_q != 8'd0);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_RESET;
      addr_q  <= 64'd0;
      rem_q   <= 40'd0;
      tag_q   <= '0;
      out_q   <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (hs && !rsp_take) begin
        out_q <= out_q + 8'd1;
      end else if (!hs && rsp_take) begin
        out_q <= out_q - 8'd1;
      end
      case (state_q)
        S_RESET: state_q <= S_IDLE;
        S_IDLE: begin
          if (start_i) state_q <= S_SET;
        end
        S_SET: begin
          addr_q  <= base_addr_i;
          rem_q   <= {8'd0, num_elements_i} << ELEM_SHIFT;
          state_q <= (num_elements_i == 32'd0) ? S_FINAL : S_START;
        end
        S_START: begin
          if (hs) begin
            addr_q <= addr_q + 64'(size_d);
            rem_q  <= rem_d;
            tag_q  <= tag_q + TAG_WIDTH'(1);
            if (rem_d == 40'd0) state_q <= S_FINAL;
          end
        end
        S_FINAL: begin
          if (out_q == 8'd0) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_RESET;
      endcase
    end
  end

  assign cmd_addr_o = addr_q;
  assign cmd_size_o = size_d;
  assign cmd_tag_o  = tag_q;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;

endmodule
